// File: rtl/nivel_cxa_pkg.sv
// Shared definitions for the tank-level sensor front end.
//
// Contents:
//   - level code constants driven onto Nv1/Nv0
//   - fill-valve FSM state type
//   - default debounce depth
//   - encode_level(): maps a debounced {alto, medio, baixo} pattern to a level code.
//     Patterns that float sensors cannot physically produce are flagged as invalid.
//
// Optional feature macro used elsewhere: FILL_TIMEOUT_EN.
package nivel_cxa_pkg;

  localparam logic [1:0] NV_VAZIA = 2'b00;
  localparam logic [1:0] NV_BAIXO = 2'b01;
  localparam logic [1:0] NV_MEDIO = 2'b10;
  localparam logic [1:0] NV_CHEIA = 2'b11;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    ENCHENDO = 2'd1,
    FALHA    = 2'd2
  } fill_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } level_t;

  // A higher sensor can only be wet if every sensor below it is wet too.
  function automatic level_t encode_level(input logic [2:0] pat);
    level_t lvl;
    lvl.valid = 1'b1;
    lvl.code  = NV_VAZIA;
    case (pat)
      3'b000:  lvl.code = NV_VAZIA;
      3'b001:  lvl.code = NV_BAIXO;
      3'b011:  lvl.code = NV_MEDIO;
      3'b111:  lvl.code = NV_CHEIA;
      default: lvl.valid = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/nivel_cxa_sensor_debounce.sv
// debounce_sensor: 2-flop synchroniser followed by a debounce counter for one
// raw, asynchronous float-sensor input.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   raw_i  in   raw sensor level (asynchronous)
//   deb_o  out  debounced, synchronous sensor level
//
// Timing: a raw change first sampled at edge 0 reaches deb_o at edge
// 2+DEB_CYCLES, provided it stays stable. Shorter glitches are discarded.
module debounce_sensor
  import nivel_cxa_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic deb_o
);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts the edges at which the synchronised value has already
  // disagreed with deb_q. The new value is accepted at the next disagreeing
  // edge after that count reaches DEB_CYCLES. Any agreeing cycle restarts the
  // count, so a short glitch never gets through.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/nivel_cxa_sensor.sv
// nivel_cxa_sensor: tank-level sensor front end.
// - Synchronises and debounces three float sensors.
// - Encodes the tank level for the 7-segment decoder.
// - Flags inconsistent sensor patterns.
// - Drives the fill valve through a hysteresis FSM.
//
// Ports:
//   clk      in   system clock (rising edge)
//   rst_n    in   asynchronous active-low reset
//   S_BAIXO  in   low float sensor, raw/asynchronous, 1 = wet
//   S_MEDIO  in   mid float sensor, raw/asynchronous
//   S_ALTO   in   high float sensor, raw/asynchronous
//   Nv1/Nv0  out  registered level code (holds last valid code)
//   VALVULA  out  registered fill-valve command, 1 = open
//   ERRO     out  registered fault flag, 1 only in FALHA
//
// Optional feature: define FILL_TIMEOUT_EN to add a fill timeout.
// In ENCHENDO, if the level does not rise for TIMEOUT_CYCLES cycles, the FSM
// forces FALHA. A sticky flag then holds FALHA until rst_n.
module nivel_cxa_sensor
  import nivel_cxa_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
`ifdef FILL_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 1000,
`endif
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic S_BAIXO,
  input  logic S_MEDIO,
  input  logic S_ALTO,
  output logic Nv1,
  output logic Nv0,
  output logic VALVULA,
  output logic ERRO
);

  logic [2:0]  deb_pat;  // {alto, medio, baixo}
  level_t      lvl;
  fill_state_e state_q, state_d;
  logic [1:0]  nv_q, nv_d;
  logic        valvula_q, valvula_d;
  logic        erro_q, erro_d;
  logic        timeout_hit;
  logic        fault_sticky;

  debounce_sensor #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_baixo (
    .clk(clk), .rst_n(rst_n), .raw_i(S_BAIXO), .deb_o(deb_pat[0])
  );
  debounce_sensor #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_medio (
    .clk(clk), .rst_n(rst_n), .raw_i(S_MEDIO), .deb_o(deb_pat[1])
  );
  debounce_sensor #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_alto (
    .clk(clk), .rst_n(rst_n), .raw_i(S_ALTO), .deb_o(deb_pat[2])
  );

  assign lvl = encode_level(deb_pat);

`ifdef FILL_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             to_flag_q, to_flag_d;
  logic             level_up;

  // Any rise in the encoded level counts as fill progress and restarts the timeout.
  always_comb begin
    level_up    = lvl.valid && (lvl.code > nv_q);
    timeout_hit = (state_q == ENCHENDO) && !level_up &&
                  (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    to_cnt_d    = ((state_q == ENCHENDO) && !level_up) ? to_cnt_q + 1'b1 : '0;
    // With a consistent pattern, ENCHENDO -> FALHA can only be the timeout.
    to_flag_d   = to_flag_q |
                  ((state_q == ENCHENDO) && (state_d == FALHA) && lvl.valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign fault_sticky = to_flag_q;
`else
  assign timeout_hit  = 1'b0;
  assign fault_sticky = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PARADO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // Priority: inconsistency, then fill complete, then start fill.
  // At NV_MEDIO neither PARADO nor ENCHENDO changes state (hysteresis band).
  always_comb begin
    state_d = state_q;
    case (state_q)
      PARADO: begin
        if (!lvl.valid)                 state_d = FALHA;
        else if (lvl.code <= NV_BAIXO)  state_d = ENCHENDO;
      end
      ENCHENDO: begin
        if (!lvl.valid)                 state_d = FALHA;
        else if (lvl.code == NV_CHEIA)  state_d = PARADO;
        else if (timeout_hit)           state_d = FALHA;
      end
      FALHA: begin
        // Leave through PARADO so the fill decision is re-evaluated next cycle.
        if (lvl.valid && !fault_sticky) state_d = PARADO;
      end
      default:                          state_d = PARADO;
    endcase
  end

  // Output logic: outputs are registered from the next state,
  // so they change on the same edge as the state.
  always_comb begin
    nv_d      = lvl.valid ? lvl.code : nv_q;
    valvula_d = (state_d == ENCHENDO);
    erro_d    = (state_d == FALHA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nv_q      <= NV_VAZIA;
      valvula_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      nv_q      <= nv_d;
      valvula_q <= valvula_d;
      erro_q    <= erro_d;
    end
  end

  assign Nv1     = nv_q[1];
  assign Nv0     = nv_q[0];
  assign VALVULA = valvula_q;
  assign ERRO    = erro_q;

endmodule
